// File: rtl/sio_pkg.sv
// Shared constants and types for the LM80C SIO-lite serial peripheral.
package sio_pkg;

    localparam logic SIO_DATA = 1'b0;
    localparam logic SIO_CTRL = 1'b1;

    localparam int unsigned ST_RXA    = 0;
    localparam int unsigned ST_OVR    = 1;
    localparam int unsigned ST_TBE    = 2;
    localparam int unsigned ST_FE     = 3;
    localparam int unsigned ST_TXBUSY = 4;
    localparam int unsigned ST_TOVR   = 5;

    localparam int unsigned CT_RXIE   = 0;
    localparam int unsigned CT_TXIE   = 1;
    localparam int unsigned CT_CRST   = 2;
    localparam int unsigned CT_CLRERR = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/sio_uart_rx.sv
// 8N1 receiver: rxd synchronizer, mid-bit sampling FSM, byte/frame-error output with done pulse.
module sio_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       fe_o,
    output logic       done_o
);
    import sio_pkg::*;

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);

    uart_state_t            state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CntW-1:0]        cnt_q;
    logic [2:0]             idx_q;
    logic [7:0]             shift_q;
    logic [7:0]             byte_q;
    logic                   fe_q;
    logic                   done_q;
    logic                   brk_q;
    logic                   rx_s;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign byte_o = byte_q;
    assign fe_o   = fe_q;
    assign done_o = done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sync_q  <= '1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            fe_q    <= 1'b0;
            done_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
            prev_q <= rx_s;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (prev_q && !rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HalfEnd) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        // A high level at mid-start means the falling edge was a glitch.
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == BitEnd) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (brk_q) begin
                        if (rx_s) begin
                            brk_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (cnt_q == BitEnd) begin
                        cnt_q  <= '0;
                        byte_q <= shift_q;
                        fe_q   <= ~rx_s;
                        done_q <= 1'b1;
                        if (rx_s) begin
                            state_q <= IDLE;
                        end else begin
                            brk_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lm80c_sio_lite.sv
// SIO-style single-channel serial peripheral for the Z80 I/O window: registers, TX FSM,
// interrupt, and the receiver sub-module.
module lm80c_sio_lite #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       sys_clock,
    input  logic       RESET,
    input  logic       sel,
    input  logic       a,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rxd,
    output logic       txd,
    output logic       int_n
);
    import sio_pkg::*;

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitEnd = CntW'(CLKS_PER_BIT - 1);

    logic            acc_wr_q, acc_wr_p_q, acc_rd_q, acc_rd_p_q;
    logic            wr_addr_q, rd_addr_q;
    logic [7:0]      wr_data_q;

    uart_state_t     tx_state_q;
    logic [CntW-1:0] tx_cnt_q;
    logic [2:0]      tx_idx_q;
    logic [7:0]      tx_shift_q, hold_q;
    logic            tbe_q, txd_q;

    logic            rx_ie_q, tx_ie_q, rxa_q, ovr_q, fe_q, tovr_q, int_n_q;
    logic [7:0]      rx_buf_q;

    logic [7:0]      rx_byte;
    logic            rx_fe, rx_done;

    logic            wr_edge, rd_fall, ctrl_wr, data_wr, data_rd, crst;
    logic            tx_bit_end, tx_load, wr_accept, rx_rst;
    logic [7:0]      status;

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            acc_wr_q   <= 1'b0;
            acc_wr_p_q <= 1'b0;
            acc_rd_q   <= 1'b0;
            acc_rd_p_q <= 1'b0;
            wr_addr_q  <= 1'b0;
            rd_addr_q  <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            acc_wr_q   <= sel & wr;
            acc_wr_p_q <= acc_wr_q;
            acc_rd_q   <= sel & rd;
            acc_rd_p_q <= acc_rd_q;
            if (sel && wr) begin
                wr_addr_q <= a;
                wr_data_q <= din;
            end
            // The read action fires after the strobe drops, so remember its address.
            if (sel && rd) begin
                rd_addr_q <= a;
            end
        end
    end

    always_comb begin
        wr_edge    = acc_wr_q & ~acc_wr_p_q;
        rd_fall    = ~acc_rd_q & acc_rd_p_q;
        ctrl_wr    = wr_edge & (wr_addr_q == SIO_CTRL);
        data_wr    = wr_edge & (wr_addr_q == SIO_DATA);
        data_rd    = rd_fall & (rd_addr_q == SIO_DATA);
        crst       = ctrl_wr & wr_data_q[CT_CRST];
        rx_rst     = RESET | crst;
        tx_bit_end = (tx_cnt_q == BitEnd);
        tx_load    = ~tbe_q & ((tx_state_q == IDLE) | ((tx_state_q == STOP) & tx_bit_end));
        // A load in the same cycle empties the holding register before the write lands.
        wr_accept  = data_wr & (tbe_q | tx_load);
    end

    always_ff @(posedge sys_clock) begin
        if (RESET || crst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            hold_q     <= '0;
            tbe_q      <= 1'b1;
            txd_q      <= 1'b1;
            rxa_q      <= 1'b0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            tovr_q     <= 1'b0;
            rx_buf_q   <= '0;
            int_n_q    <= 1'b1;
            rx_ie_q    <= RESET ? 1'b0 : wr_data_q[CT_RXIE];
            tx_ie_q    <= RESET ? 1'b0 : wr_data_q[CT_TXIE];
        end else begin
            int_n_q <= ~((rx_ie_q & rxa_q) | (tx_ie_q & tbe_q));

            if (ctrl_wr) begin
                rx_ie_q <= wr_data_q[CT_RXIE];
                tx_ie_q <= wr_data_q[CT_TXIE];
                if (wr_data_q[CT_CLRERR]) begin
                    ovr_q  <= 1'b0;
                    fe_q   <= 1'b0;
                    tovr_q <= 1'b0;
                end
            end

            case (tx_state_q)
                IDLE: begin
                    if (tx_load) begin
                        tx_shift_q <= hold_q;
                        txd_q      <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= START;
                    end
                end
                START: begin
                    if (tx_bit_end) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        txd_q      <= tx_shift_q[0];
                        tx_state_q <= DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= STOP;
                        end else begin
                            txd_q      <= tx_shift_q[1];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_idx_q   <= tx_idx_q + 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= '0;
                        if (tx_load) begin
                            tx_shift_q <= hold_q;
                            txd_q      <= 1'b0;
                            tx_state_q <= START;
                        end else begin
                            tx_state_q <= IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= IDLE;
            endcase

            if (wr_accept) begin
                hold_q <= wr_data_q;
                tbe_q  <= 1'b0;
            end else if (tx_load) begin
                tbe_q <= 1'b1;
            end
            if (data_wr && !wr_accept) begin
                tovr_q <= 1'b1;
            end

            // A byte completing alongside the data-read edge keeps RXA set without overrun.
            if (rx_done) begin
                rx_buf_q <= rx_byte;
                rxa_q    <= 1'b1;
                if (rxa_q && !data_rd) begin
                    ovr_q <= 1'b1;
                end
                if (rx_fe) begin
                    fe_q <= 1'b1;
                end
            end else if (data_rd) begin
                rxa_q <= 1'b0;
            end
        end
    end

    always_comb begin
        status            = '0;
        status[ST_RXA]    = rxa_q;
        status[ST_OVR]    = ovr_q;
        status[ST_TBE]    = tbe_q;
        status[ST_FE]     = fe_q;
        status[ST_TXBUSY] = (tx_state_q != IDLE);
        status[ST_TOVR]   = tovr_q;
        dout              = (a == SIO_CTRL) ? status : rx_buf_q;
    end

    assign txd   = txd_q;
    assign int_n = int_n_q;

    sio_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx (
        .clk_i  (sys_clock),
        .rst_i  (rx_rst),
        .rxd_i  (rxd),
        .byte_o (rx_byte),
        .fe_o   (rx_fe),
        .done_o (rx_done)
    );

endmodule

// File: tb/tb_lm80c_sio_lite.sv
// Directed bench for lm80c_sio_lite with TX/RX byte scoreboards.
module tb_lm80c_sio_lite;
    localparam int unsigned CLKS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       a = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       rxd = 1'b1;
    logic       txd;
    logic       int_n;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         frames = 0;
    int         drv_cyc = 0;
    bit         mon_en = 1'b1;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int         starts[$];

    lm80c_sio_lite #(
        .CLKS_PER_BIT (CLKS),
        .SYNC_STAGES  (2)
    ) dut (
        .sys_clock (clk),
        .RESET     (rst),
        .sel       (sel),
        .a         (a),
        .rd        (rd),
        .wr        (wr),
        .din       (din),
        .dout      (dout),
        .rxd       (rxd),
        .txd       (txd),
        .int_n     (int_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic addr, input logic [7:0] d);
        drv_cyc = cyc;
        sel = 1'b1; a = addr; wr = 1'b1; din = d;
        tick(2);
        sel = 1'b0; wr = 1'b0;
        tick(2);
    endtask

    task automatic bus_rd(input logic addr, output logic [7:0] d);
        sel = 1'b1; a = addr; rd = 1'b1;
        tick(1);
        d = dout;
        sel = 1'b0; rd = 1'b0;
        tick(2);
    endtask

    task automatic status_is(input string tag, input logic [7:0] exp);
        logic [7:0] s;
        bus_rd(1'b1, s);
        check(tag, int'(s), int'(exp));
    endtask

    task automatic read_pop(input string tag);
        logic [7:0] d;
        bus_rd(1'b0, d);
        if (rxq.size() == 0) begin
            check({tag, "_rxq_empty"}, 1, 0);
        end else begin
            check(tag, int'(d), int'(rxq.pop_front()));
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        tick(CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CLKS);
        end
        rxd = stop_bit;
        tick(CLKS);
        rxd = 1'b1;
        tick(4);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames < n && k < budget) begin
            tick(1);
            k++;
        end
        check("tx_frames", frames, n);
    endtask

    // TX monitor: decode txd at mid-bit and compare against the expected-byte queue.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && txd === 1'b0) begin
                starts.push_back(cyc);
                tick(CLKS / 2 - 1);
                check("tx_start_bit", int'(txd), 0);
                for (int i = 0; i < 8; i++) begin
                    tick(CLKS);
                    b[i] = txd;
                end
                tick(CLKS);
                check("tx_stop_bit", int'(txd), 1);
                if (txq.size() == 0) begin
                    check("tx_unexpected_frame", int'(b), -1);
                end else begin
                    check("tx_byte", int'(b), int'(txq.pop_front()));
                end
                frames++;
            end
        end
    end

    initial begin
        logic [7:0] d;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        status_is("reset_status", 8'h04);
        check("reset_txd", int'(txd), 1);
        check("reset_int_n", int'(int_n), 1);
        a = 1'b0;
        tick(1);
        check("reset_rxbuf", int'(dout), 0);

        // Single frame 0xA5 with latency and timing
        txq.push_back(8'hA5);
        bus_wr(1'b0, 8'hA5);
        status_is("tx_busy_status", 8'h14);
        wait_frames(1, 400);
        check("tx_latency", starts[0] - drv_cyc, 3);
        tick(10);
        status_is("tx_done_status", 8'h04);

        // Back-to-back frames plus a dropped third write
        txq.push_back(8'h55);
        bus_wr(1'b0, 8'h55);
        txq.push_back(8'h0F);
        bus_wr(1'b0, 8'h0F);
        bus_wr(1'b0, 8'h33);
        status_is("tovr_status", 8'h30);
        wait_frames(3, 600);
        check("b2b_gap", starts[2] - starts[1], 10 * CLKS);
        tick(20);
        status_is("tovr_idle_status", 8'h24);
        bus_wr(1'b1, 8'h08);
        status_is("tovr_cleared", 8'h04);
        tick(200);
        check("no_third_frame", frames, 3);

        // Receive, then overrun
        rxq.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        status_is("rxa_status", 8'h05);
        read_pop("rx_3c");
        status_is("rxa_cleared", 8'h04);
        send_rx(8'h11, 1'b1);
        rxq.push_back(8'h22);
        send_rx(8'h22, 1'b1);
        status_is("ovr_status", 8'h07);
        read_pop("rx_overrun_byte");
        status_is("ovr_after_read", 8'h06);
        bus_wr(1'b1, 8'h08);
        status_is("ovr_cleared", 8'h04);

        // Framing error, glitch rejection
        rxq.push_back(8'h5A);
        send_rx(8'h5A, 1'b0);
        status_is("fe_status", 8'h0D);
        read_pop("rx_fe_byte");
        bus_wr(1'b1, 8'h08);
        status_is("fe_cleared", 8'h04);
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        tick(40);
        status_is("glitch_status", 8'h04);
        rxq.push_back(8'h81);
        send_rx(8'h81, 1'b1);
        read_pop("rx_after_glitch");

        // Interrupts
        bus_wr(1'b1, 8'h03);
        tick(2);
        check("int_tbe", int'(int_n), 0);
        bus_wr(1'b1, 8'h01);
        tick(2);
        check("int_masked", int'(int_n), 1);
        rxq.push_back(8'h77);
        send_rx(8'h77, 1'b1);
        check("int_rxa", int'(int_n), 0);
        read_pop("rx_int_byte");
        tick(1);
        check("int_after_read", int'(int_n), 1);

        // Channel reset keeps the written enables
        send_rx(8'h99, 1'b1);
        status_is("pre_crst_status", 8'h05);
        bus_wr(1'b1, 8'h06);
        status_is("crst_status", 8'h04);
        a = 1'b0;
        tick(1);
        check("crst_rxbuf", int'(dout), 0);
        check("crst_int_tx_ie", int'(int_n), 0);

        // Reset mid-frame
        mon_en = 1'b0;
        bus_wr(1'b0, 8'h00);
        tick(20);
        check("midframe_txd_low", int'(txd), 0);
        rst = 1'b1;
        tick(1);
        check("reset_midframe_txd", int'(txd), 1);
        rst = 1'b0;
        tick(2);
        status_is("reset_midframe_status", 8'h04);
        check("reset_midframe_int_n", int'(int_n), 1);

        check("txq_drained", txq.size(), 0);
        check("rxq_drained", rxq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
